// File: rtl/afifo_wr_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afifo_wr_engine_pkg
// Description : Shared types and sizing helpers for the async FIFO write-side
//               burst engine.
// Revision    : 1.0 - initial release
// ============================================================================
package afifo_wr_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_STREAM  = 1'b0,
        MODE_PATTERN = 1'b1
    } mode_t;

    localparam int C_TIMEOUT_DEFAULT = 1024;

    // Stall counter width is $clog2(TIMEOUT+1); never narrower than one bit.
    function automatic int stall_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/afifo_wr_stat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : afifo_wr_stat_cnt
// Description : Saturating statistics counter with synchronous clear that
//               takes priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module afifo_wr_stat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/afifo_wr_burst_engine.sv
`default_nettype none
// ============================================================================
// Module      : afifo_wr_burst_engine
// Description : Write-side burst engine for the async FIFO: accepts burst
//               commands, writes stream or pattern data, aborts on full stall.
// Revision    : 1.0 - initial release
// ============================================================================
module afifo_wr_burst_engine
    import afifo_wr_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int TIMEOUT    = C_TIMEOUT_DEFAULT,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_mode,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    input  logic                  clr_stats,
    output logic [CNT_WIDTH-1:0]  stat_writes,
    output logic [CNT_WIDTH-1:0]  stat_full_cycles
);

    localparam int STALL_W = stall_width(TIMEOUT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  w_beat_nxt;
    mode_t                 r_mode;
    logic [DATA_WIDTH-1:0] r_pat;
    logic [STALL_W-1:0]    r_stall_cnt;
    logic                  r_abort;

    logic w_run;
    logic w_data_avail;
    logic w_winc;
    logic w_stall;
    logic w_last;
    logic w_timeout;
    logic w_accept;

    assign w_run        = (r_state == RUN);
    assign w_data_avail = (r_mode == MODE_PATTERN) || s_valid;
    // Write gating is purely combinational on wfull so a full FIFO is never overrun.
    assign w_winc       = w_run && w_data_avail && !wfull;
    assign w_stall      = w_run && w_data_avail && wfull;
    assign w_beat_nxt   = r_beat_cnt + 1'b1;
    assign w_last       = w_winc && (w_beat_nxt == r_len);
    assign w_accept     = (r_state == IDLE) && cmd_valid;

    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam logic [STALL_W-1:0] C_STALL_LAST = STALL_W'(TIMEOUT - 1);
            assign w_timeout = w_stall && (r_stall_cnt == C_STALL_LAST);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err_timeout = 1'b0;
        winc        = 1'b0;
        s_ready     = 1'b0;
        wdata       = '0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = (cmd_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                winc    = w_winc;
                s_ready = (r_mode == MODE_STREAM) && !wfull;
                wdata   = (r_mode == MODE_PATTERN) ? r_pat : s_data;
                if (w_last || w_timeout) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                done        = 1'b1;
                err_timeout = r_abort;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_len       <= '0;
            r_mode      <= MODE_STREAM;
            r_pat       <= '0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_abort     <= 1'b0;
        end else if (w_accept) begin
            r_len       <= cmd_len;
            r_mode      <= mode_t'(cmd_mode);
            r_pat       <= cmd_seed;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_abort     <= 1'b0;
        end else if (w_winc) begin
            r_beat_cnt  <= w_beat_nxt;
            r_pat       <= r_pat + 1'b1;
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            // Stall count only advances while data is waiting on wfull.
            r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_timeout) begin
                r_abort <= 1'b1;
            end
        end
    end

    afifo_wr_stat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_stat_writes (
        .clk     (wclk),
        .rst_n   (wrst_n),
        .i_clr   (clr_stats),
        .i_inc   (w_winc),
        .o_count (stat_writes)
    );

    afifo_wr_stat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_stat_full (
        .clk     (wclk),
        .rst_n   (wrst_n),
        .i_clr   (clr_stats),
        .i_inc   (w_stall),
        .o_count (stat_full_cycles)
    );

endmodule
`default_nettype wire

// File: tb/tb_afifo_wr_burst_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_afifo_wr_burst_engine
// Description : Directed self-checking bench for afifo_wr_burst_engine
//               (TIMEOUT=16, 4-bit saturating statistics counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afifo_wr_burst_engine;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = AW + 1;
    localparam int TO = 16;
    localparam int CW = 4;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_mode = 1'b0;
    logic [DW-1:0] cmd_seed = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          wfull = 1'b0;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] stat_writes;
    logic [CW-1:0] stat_full_cycles;

    int checks = 0;
    int errors = 0;

    afifo_wr_burst_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .wclk             (wclk),
        .wrst_n           (wrst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_len          (cmd_len),
        .cmd_mode         (cmd_mode),
        .cmd_seed         (cmd_seed),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .wfull            (wfull),
        .winc             (winc),
        .wdata            (wdata),
        .busy             (busy),
        .done             (done),
        .err_timeout      (err_timeout),
        .clr_stats        (clr_stats),
        .stat_writes      (stat_writes),
        .stat_full_cycles (stat_full_cycles)
    );

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_writes", 32'(stat_writes), 32'd0);
        chk("clr_full", 32'(stat_full_cycles), 32'd0);
    endtask

    task automatic issue(input int len, input logic mode, input logic [DW-1:0] seed);
        cmd_valid = 1'b1;
        cmd_len   = len[LW-1:0];
        cmd_mode  = mode;
        cmd_seed  = seed;
        #2;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called at the start of the FIN cycle; returns one cycle into IDLE.
    task automatic fin_check(input logic exp_err);
        #2;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_err", 32'(err_timeout), 32'(exp_err));
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_winc", 32'(winc), 32'd0);
        chk("fin_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        #2;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_err", 32'(err_timeout), 32'd0);
        tick();
    endtask

    logic [DW-1:0] exp_w;
    logic [DW-1:0] sd_tab [4];
    logic          sv_tab [4];

    initial begin
        // Reset values
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_stat_writes", 32'(stat_writes), 32'd0);
        chk("rst_stat_full", 32'(stat_full_cycles), 32'd0);
        tick();
        tick();
        wrst_n = 1'b1;
        tick();

        // Pattern len=4 seed 0x10; a competing command is held and must be ignored
        issue(4, 1'b1, 32'h10);
        cmd_valid = 1'b1;
        cmd_len   = 9'd1;
        cmd_seed  = 32'h99;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("p4_winc", 32'(winc), 32'd1);
            chk("p4_wdata", wdata, 32'h10 + 32'(i));
            chk("p4_busy", 32'(busy), 32'd1);
            chk("p4_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        fin_check(1'b0);
        chk("p4_stat_writes", 32'(stat_writes), 32'd4);

        // Stream len=3, s_valid 1,0,1,1
        clear_stats();
        sv_tab = '{1'b1, 1'b0, 1'b1, 1'b1};
        sd_tab = '{32'hA1A1_0001, 32'hDEAD_BEEF, 32'hA3A3_0003, 32'hA4A4_0004};
        issue(3, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            s_valid = sv_tab[i];
            s_data  = sd_tab[i];
            #2;
            chk("st_winc", 32'(winc), 32'(sv_tab[i]));
            if (sv_tab[i]) begin
                chk("st_s_ready", 32'(s_ready), 32'd1);
                chk("st_wdata", wdata, sd_tab[i]);
            end
            tick();
        end
        s_valid = 1'b0;
        fin_check(1'b0);
        chk("st_stat_writes", 32'(stat_writes), 32'd3);
        chk("st_stat_full", 32'(stat_full_cycles), 32'd0);

        // Pattern len=8 across the 32-bit wrap, wfull high on burst cycles 3..6
        clear_stats();
        issue(8, 1'b1, 32'hFFFF_FFFE);
        exp_w = 32'hFFFF_FFFE;
        for (int c = 1; c <= 12; c++) begin
            wfull = (c >= 3) && (c <= 6);
            #2;
            chk("stall_winc", 32'(winc), 32'(!wfull));
            chk("stall_busy", 32'(busy), 32'd1);
            if (!wfull) begin
                chk("stall_wdata", wdata, exp_w);
                exp_w = exp_w + 1'b1;
            end
            tick();
        end
        wfull = 1'b0;
        fin_check(1'b0);
        chk("stall_stat_writes", 32'(stat_writes), 32'd8);
        chk("stall_stat_full", 32'(stat_full_cycles), 32'd4);

        // wfull rises on the last beat: engine waits, then writes it
        clear_stats();
        issue(2, 1'b1, 32'h20);
        for (int c = 1; c <= 4; c++) begin
            wfull = (c == 2) || (c == 3);
            #2;
            chk("lastfull_winc", 32'(winc), 32'(!wfull));
            chk("lastfull_done", 32'(done), 32'd0);
            if (!wfull) chk("lastfull_wdata", wdata, (c == 1) ? 32'h20 : 32'h21);
            tick();
        end
        wfull = 1'b0;
        fin_check(1'b0);
        chk("lastfull_stat_full", 32'(stat_full_cycles), 32'd2);

        // Timeout: 2 writes then permanent wfull; abort on the 16th stalled cycle
        clear_stats();
        issue(8, 1'b1, 32'h40);
        for (int c = 1; c <= 18; c++) begin
            wfull = (c >= 3);
            #2;
            chk("to_busy", 32'(busy), 32'd1);
            chk("to_winc", 32'(winc), 32'(c < 3));
            if (c < 3) chk("to_wdata", wdata, 32'h40 + 32'(c - 1));
            tick();
        end
        fin_check(1'b1);
        wfull = 1'b0;
        chk("to_stat_writes", 32'(stat_writes), 32'd2);
        // 16 stalled cycles saturate the 4-bit counter at 15
        chk("to_stat_full_sat", 32'(stat_full_cycles), 32'd15);

        // Empty burst
        clear_stats();
        issue(0, 1'b1, 32'h77);
        fin_check(1'b0);
        chk("len0_stat_writes", 32'(stat_writes), 32'd0);

        // stat_writes saturation over a 20-beat burst
        clear_stats();
        issue(20, 1'b1, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            tick();
        end
        fin_check(1'b0);
        chk("sat_stat_writes", 32'(stat_writes), 32'd15);

        // clr_stats coinciding with a write: clear wins
        clear_stats();
        issue(3, 1'b1, 32'h0);
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        tick();
        fin_check(1'b0);
        chk("clrwin_stat_writes", 32'(stat_writes), 32'd1);

        // Reset mid-burst after 5 of 10 writes
        issue(10, 1'b1, 32'h100);
        for (int c = 1; c <= 5; c++) begin
            #2;
            chk("mid_wdata", wdata, 32'h100 + 32'(c - 1));
            tick();
        end
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_winc", 32'(winc), 32'd0);
        chk("mid_rst_wdata", wdata, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_stat_writes", 32'(stat_writes), 32'd0);
        tick();
        wrst_n = 1'b1;
        tick();
        #2;
        chk("post_rst_done", 32'(done), 32'd0);
        tick();
        issue(2, 1'b1, 32'h55);
        for (int c = 1; c <= 2; c++) begin
            #2;
            chk("post_rst_winc", 32'(winc), 32'd1);
            chk("post_rst_wdata", wdata, 32'h55 + 32'(c - 1));
            tick();
        end
        fin_check(1'b0);
        chk("post_rst_stat_writes", 32'(stat_writes), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
